// File: rtl/dct_block_scheduler.sv
// Block scheduler ahead of rgb2ycbcr_dct_combined: gathers 8 RGB rows into an 8x8
// block, hands it to the core, forwards the result with its block index, and guards core latency.
module dct_block_scheduler #(
  parameter int unsigned INPUT_WIDTH    = 8,
  parameter int unsigned BLK_CNT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [BLK_CNT_W-1:0]        cfg_num_blocks,
  output logic                        busy,
  output logic                        done,
  output logic                        err_timeout,
  input  logic                        row_valid,
  output logic                        row_ready,
  input  logic [8*INPUT_WIDTH-1:0]    row_r,
  input  logic [8*INPUT_WIDTH-1:0]    row_g,
  input  logic [8*INPUT_WIDTH-1:0]    row_b,
  output logic                        core_in_valid,
  input  logic                        core_in_ready,
  output logic [64*INPUT_WIDTH-1:0]   core_r_all,
  output logic [64*INPUT_WIDTH-1:0]   core_g_all,
  output logic [64*INPUT_WIDTH-1:0]   core_b_all,
  input  logic                        core_out_valid,
  output logic                        core_out_ready,
  output logic                        blk_out_valid,
  input  logic                        blk_out_ready,
  output logic [BLK_CNT_W-1:0]        blk_index
);

  localparam int unsigned ROW_W = 8 * INPUT_WIDTH;
  localparam int unsigned BLK_W = 64 * INPUT_WIDTH;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]           state;
  logic [BLK_CNT_W-1:0] count;
  logic [2:0]           row_cnt;
  logic [WD_W-1:0]      wdog;
  logic [BLK_W-1:0]     buf_r, buf_g, buf_b;
  logic                 last_blk;

  assign last_blk       = (blk_index == count - 1'b1);
  assign busy           = (state == S_FILL) || (state == S_ISSUE) || (state == S_WAIT);
  assign row_ready      = (state == S_FILL);
  assign core_in_valid  = (state == S_ISSUE);
  assign blk_out_valid  = (state == S_WAIT) && core_out_valid;
  assign core_out_ready = (state == S_WAIT) && blk_out_ready;
  assign core_r_all     = buf_r;
  assign core_g_all     = buf_g;
  assign core_b_all     = buf_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      blk_index   <= '0;
      row_cnt     <= '0;
      wdog        <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        row_cnt     <= '0;
        blk_index   <= '0;
        wdog        <= '0;
        err_timeout <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_num_blocks != '0) begin
                count     <= cfg_num_blocks;
                blk_index <= '0;
                row_cnt   <= '0;
                state     <= S_FILL;
              end else begin
                done <= 1'b1;
              end
            end
          end
          S_FILL: begin
            if (row_valid) begin
              // row_cnt wraps back to 0 on the 8th row
              row_cnt <= row_cnt + 3'd1;
              if (row_cnt == 3'd7) state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (core_in_ready) begin
              state <= S_WAIT;
              wdog  <= '0;
            end
          end
          S_WAIT: begin
            // A result on the wire always beats watchdog expiry
            if (core_out_valid) begin
              if (blk_out_ready) begin
                if (last_blk) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                end else begin
                  blk_index <= blk_index + 1'b1;
                  state     <= S_FILL;
                end
              end
            end else if (wdog == WD_LAST) begin
              state       <= S_ERR;
              err_timeout <= 1'b1;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          S_ERR:   state <= S_ERR;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r <= '0;
      buf_g <= '0;
      buf_b <= '0;
    end else if (!abort && state == S_FILL && row_valid) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (row_cnt == 3'(k)) begin
          buf_r[k*ROW_W +: ROW_W] <= row_r;
          buf_g[k*ROW_W +: ROW_W] <= row_g;
          buf_b[k*ROW_W +: ROW_W] <= row_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Directed/random bench for dct_block_scheduler; a second instance with a short
// watchdog shares all inputs and is only checked in the watchdog scenarios.
module tb_dct_block_scheduler;

  localparam int unsigned W  = 8;
  localparam int unsigned BW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort, row_valid, core_in_ready, core_out_valid, blk_out_ready;
  logic [BW-1:0] cfg_num_blocks;
  logic [8*W-1:0] row_r, row_g, row_b;

  logic           busy, done, err_timeout, row_ready, core_in_valid, core_out_ready, blk_out_valid;
  logic [64*W-1:0] core_r_all, core_g_all, core_b_all;
  logic [BW-1:0]   blk_index;

  logic           w_busy, w_done, w_err, w_row_ready, w_core_in_valid, w_core_out_ready, w_blk_out_valid;
  logic [64*W-1:0] w_r_all, w_g_all, w_b_all;
  logic [BW-1:0]   w_blk_index;

  dct_block_scheduler #(.INPUT_WIDTH(W), .BLK_CNT_W(BW), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_num_blocks(cfg_num_blocks),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .row_valid(row_valid), .row_ready(row_ready), .row_r(row_r), .row_g(row_g), .row_b(row_b),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_r_all(core_r_all), .core_g_all(core_g_all), .core_b_all(core_b_all),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready), .blk_index(blk_index)
  );

  dct_block_scheduler #(.INPUT_WIDTH(W), .BLK_CNT_W(BW), .TIMEOUT_CYCLES(16)) dut_wd (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_num_blocks(cfg_num_blocks),
    .busy(w_busy), .done(w_done), .err_timeout(w_err),
    .row_valid(row_valid), .row_ready(w_row_ready), .row_r(row_r), .row_g(row_g), .row_b(row_b),
    .core_in_valid(w_core_in_valid), .core_in_ready(core_in_ready),
    .core_r_all(w_r_all), .core_g_all(w_g_all), .core_b_all(w_b_all),
    .core_out_valid(core_out_valid), .core_out_ready(w_core_out_ready),
    .blk_out_valid(w_blk_out_valid), .blk_out_ready(blk_out_ready), .blk_index(w_blk_index)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [64*W-1:0] exp_r, exp_g, exp_b;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [BW-1:0] c);
    start = 1'b1;
    cfg_num_blocks = c;
    step();
    start = 1'b0;
  endtask

  // Presents rows (optionally with random gaps); the model records each row that is
  // offered while the scheduler is filling, in acceptance order.
  task automatic feed(input int unsigned nrows, input bit pattern, input bit stall);
    int unsigned acc = 0;
    int unsigned guard = 0;
    while (acc < nrows && guard < 200) begin
      row_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      for (int p = 0; p < 8; p++) begin
        if (pattern) begin
          row_r[p*W +: W] = W'(acc * 8 + p);
          row_g[p*W +: W] = 8'h80;
          row_b[p*W +: W] = 8'hFF;
        end else begin
          row_r[p*W +: W] = W'($urandom);
          row_g[p*W +: W] = W'($urandom);
          row_b[p*W +: W] = W'($urandom);
        end
      end
      #1 chk("row_ready_fill", row_ready, 1);
      if (row_valid) begin
        exp_r[acc*8*W +: 8*W] = row_r;
        exp_g[acc*8*W +: 8*W] = row_g;
        exp_b[acc*8*W +: 8*W] = row_b;
      end
      step();
      if (row_valid) acc++;
      guard++;
    end
    row_valid = 1'b0;
    if (guard >= 200) chk("feed_budget", 0, 1);
  endtask

  task automatic issue(input int unsigned delay);
    chk("buf_r", core_r_all, exp_r);
    chk("buf_g", core_g_all, exp_g);
    chk("buf_b", core_b_all, exp_b);
    for (int d = 0; d < int'(delay); d++) begin
      chk("in_valid_hold", core_in_valid, 1);
      chk("row_ready_issue", row_ready, 0);
      chk("busy_issue", busy, 1);
      step();
    end
    core_in_ready = 1'b1;
    #1 chk("in_valid_hs", core_in_valid, 1);
    chk("buf_r_hs", core_r_all, exp_r);
    step();
    core_in_ready = 1'b0;
    chk("in_valid_after", core_in_valid, 0);
    chk("busy_wait", busy, 1);
    chk("row_ready_wait", row_ready, 0);
  endtask

  task automatic ret(input int unsigned lat, input int unsigned bp, input logic [BW-1:0] idx,
                     input bit last, input bit inject_start);
    for (int i = 0; i < int'(lat); i++) begin
      core_out_valid = 1'b0;
      if (inject_start && i == 0) begin
        start = 1'b1;
        cfg_num_blocks = 16'd1;
      end
      #1 chk("blk_valid_idle", blk_out_valid, 0);
      chk("idx_wait", blk_index, idx);
      chk("row_ready_wait2", row_ready, 0);
      step();
      start = 1'b0;
    end
    core_out_valid = 1'b1;
    blk_out_ready  = 1'b0;
    for (int i = 0; i < int'(bp); i++) begin
      #1 chk("blk_valid_bp", blk_out_valid, 1);
      chk("core_ready_bp", core_out_ready, 0);
      chk("idx_bp", blk_index, idx);
      step();
    end
    blk_out_ready = 1'b1;
    #1 chk("core_ready_hs", core_out_ready, 1);
    chk("blk_valid_hs", blk_out_valid, 1);
    chk("idx_hs", blk_index, idx);
    step();
    core_out_valid = 1'b0;
    blk_out_ready  = 1'b0;
    if (last) begin
      chk("done_pulse", done, 1);
      chk("busy_end", busy, 0);
      step();
      chk("done_once", done, 0);
      chk("busy_idle", busy, 0);
    end else begin
      chk("done_mid", done, 0);
      chk("row_ready_next", row_ready, 1);
      chk("idx_next", blk_index, idx + 1'b1);
    end
  endtask

  initial begin
    logic [64*W-1:0] pat;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_num_blocks = '0;
    row_valid = 1'b0; row_r = '0; row_g = '0; row_b = '0;
    core_in_ready = 1'b0; core_out_valid = 1'b1; blk_out_ready = 1'b1;
    exp_r = '0; exp_g = '0; exp_b = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_row_ready", row_ready, 0);
    chk("rst_in_valid", core_in_valid, 0);
    chk("rst_out_ready", core_out_ready, 0);
    chk("rst_blk_valid", blk_out_valid, 0);
    chk("rst_idx", blk_index, 0);
    chk("rst_buf", core_r_all, 0);
    core_out_valid = 1'b0; blk_out_ready = 1'b0;
    rst_n = 1'b1;
    step();

    // single block with the ramp pattern
    go(16'd1);
    chk("t1_busy", busy, 1);
    chk("t1_idx", blk_index, 0);
    feed(8, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) pat[i*W +: W] = W'(i);
    chk("t1_ramp", core_r_all, pat);
    issue(3);
    ret(20, 0, 16'd0, 1'b1, 1'b0);

    // three blocks, stalls and back-pressure, stray start during WAIT of block 1
    go(16'd3);
    for (int b = 0; b < 3; b++) begin
      feed(8, 1'b0, 1'b1);
      issue(5);
      ret($urandom_range(3, 10), 4, BW'(b), b == 2, b == 1);
    end

    // zero-count job
    go(16'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_row_ready", row_ready, 0);
    step();
    chk("z_done_once", done, 0);
    chk("z_row_ready2", row_ready, 0);

    // abort in the middle of block 1, then a fresh job
    go(16'd2);
    feed(8, 1'b0, 1'b1);
    issue(1);
    ret(3, 0, 16'd0, 1'b0, 1'b0);
    feed(4, 1'b0, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_row_ready", row_ready, 0);
    chk("ab_idx", blk_index, 0);
    chk("ab_done", done, 0);
    go(16'd1);
    feed(8, 1'b0, 1'b0);
    issue(0);
    ret(2, 1, 16'd0, 1'b1, 1'b0);

    // abort coinciding with the issue handshake
    go(16'd1);
    feed(8, 1'b0, 1'b0);
    core_in_ready = 1'b1; abort = 1'b1;
    step();
    core_in_ready = 1'b0; abort = 1'b0;
    chk("abhs_busy", busy, 0);
    chk("abhs_in_valid", core_in_valid, 0);

    // watchdog on the short-timeout instance
    chk("wd_pre_err", w_err, 0);
    go(16'd1);
    feed(8, 1'b0, 1'b0);
    chk("wd_in_valid", w_core_in_valid, 1);
    issue(0);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c < 16) begin
        chk("wd_err_early", w_err, 0);
        chk("wd_busy_early", w_busy, 1);
      end else begin
        chk("wd_err_set", w_err, 1);
        chk("wd_busy_err", w_busy, 0);
        chk("wd_in_valid_err", w_core_in_valid, 0);
        chk("wd_row_ready_err", w_row_ready, 0);
      end
    end
    go(16'd1);
    chk("wd_start_ign_err", w_err, 1);
    chk("wd_start_ign_busy", w_busy, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("wd_abort_err", w_err, 0);
    chk("wd_abort_busy", w_busy, 0);
    chk("main_abort_busy", busy, 0);
    go(16'd0);
    chk("wd_idle_done", w_done, 1);
    chk("main_idle_done", done, 1);

    // result arriving on the cycle the watchdog would expire
    go(16'd1);
    feed(8, 1'b0, 1'b0);
    issue(0);
    for (int c = 1; c <= 15; c++) step();
    chk("race_err_pre", w_err, 0);
    core_out_valid = 1'b1; blk_out_ready = 1'b1;
    step();
    core_out_valid = 1'b0; blk_out_ready = 1'b0;
    chk("race_done", w_done, 1);
    chk("race_err", w_err, 0);
    chk("race_main_done", done, 1);

    // asynchronous reset mid-fill
    go(16'd1);
    feed(3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("arst_row_ready", row_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_buf", core_r_all, 0);
    chk("arst_wd_busy", w_busy, 0);
    #3 rst_n = 1'b1;
    step();
    chk("arst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
